// File: rtl/input_pkg.sv
// input_pkg: shared types, channel indices and counter sizing for the action input conditioner.
package input_pkg;
  typedef enum logic [2:0] {BLOCK, IDLE, QUAL_ON, ACTIVE, QUAL_OFF} ch_state_t;
  localparam int CH_JUMP = 0;
  localparam int CH_DUCK = 1;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/action_channel.sv
// action_channel: qualify one synchronised source, enforce minimum hold, emit level/rise and a saturating event count.
module action_channel
  import input_pkg::*;
#(
  parameter int CW       = 8,
  parameter int MIN_HOLD = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_src,
  input  logic             i_force,
  input  logic [CW-1:0]    i_qual,
  input  logic             i_clr,
  output logic             o_level,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_count
);
  localparam logic [CW-1:0] HOLD = CW'(MIN_HOLD);
  ch_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic w_hit, w_rise;
  // One counter serves both qualification and hold; it saturates instead of wrapping.
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  assign w_hit     = w_cnt_inc >= i_qual;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (i_force) begin
      w_state_nxt = BLOCK;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        BLOCK: begin
          w_state_nxt = (!i_src && w_hit) ? IDLE : BLOCK;
          w_cnt_nxt   = (i_src || w_hit) ? '0 : w_cnt_inc;
        end
        IDLE: begin
          w_state_nxt = i_src ? (w_hit ? ACTIVE : QUAL_ON) : IDLE;
          w_cnt_nxt   = i_src ? CW'(1) : '0;
        end
        QUAL_ON: begin
          w_state_nxt = !i_src ? IDLE : (w_hit ? ACTIVE : QUAL_ON);
          w_cnt_nxt   = !i_src ? '0 : (w_hit ? CW'(1) : w_cnt_inc);
        end
        ACTIVE: begin
          w_state_nxt = (!i_src && r_cnt >= HOLD) ? QUAL_OFF : ACTIVE;
          w_cnt_nxt   = (!i_src && r_cnt >= HOLD) ? '0 : w_cnt_inc;
        end
        QUAL_OFF: begin
          w_state_nxt = i_src ? ACTIVE : (w_hit ? IDLE : QUAL_OFF);
          w_cnt_nxt   = i_src ? HOLD : (w_hit ? '0 : w_cnt_inc);
        end
        default: begin
          w_state_nxt = BLOCK;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
  assign w_rise = (r_state == IDLE || r_state == QUAL_ON) && w_state_nxt == ACTIVE;
  // The count follows the visible rise pulse, so a clear in the same cycle keeps that event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= BLOCK;
      r_cnt   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      o_level <= (w_state_nxt == ACTIVE) || (w_state_nxt == QUAL_OFF);
      o_rise  <= w_rise;
      o_count <= i_clr ? CNT_W'(o_rise) : ((o_rise && !(&o_count)) ? o_count + 1'b1 : o_count);
    end
  end
endmodule

// File: rtl/action_input_conditioner.sv
// action_input_conditioner: synchronise buttons/sensor levels/mode, pick the source per channel and fan out to channel FSMs.
module action_input_conditioner
  import input_pkg::*;
#(
  parameter int                N_CH            = 2,
  parameter logic [N_CH-1:0]   BTN_ACTIVE_LOW  = 2'b10,
  parameter int                DEBOUNCE_CYCLES = 330000,
  parameter int                SENSOR_QUAL     = 1,
  parameter int                MIN_HOLD        = 3300000,
  parameter int                CNT_W           = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sensor_mode,
  input  logic [N_CH-1:0]       btn_raw,
  input  logic [N_CH-1:0]       sensor_lvl,
  input  logic                  clr_counts,
  output logic [N_CH-1:0]       action_level,
  output logic [N_CH-1:0]       action_rise,
  output logic [N_CH*CNT_W-1:0] event_count
);
  localparam int CW = cnt_width(max3(DEBOUNCE_CYCLES, SENSOR_QUAL, MIN_HOLD));
  logic [N_CH-1:0] r_btn_m, r_btn_s, r_sen_m, r_sen_s, w_src;
  logic r_mode_m, r_mode_s, r_mode_d, w_mode_chg;
  logic [CW-1:0] w_qual;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btn_m  <= '0;
      r_btn_s  <= '0;
      r_sen_m  <= '0;
      r_sen_s  <= '0;
      r_mode_m <= 1'b0;
      r_mode_s <= 1'b0;
      r_mode_d <= 1'b0;
    end else begin
      r_btn_m  <= btn_raw;
      r_btn_s  <= r_btn_m;
      r_sen_m  <= sensor_lvl;
      r_sen_s  <= r_sen_m;
      r_mode_m <= sensor_mode;
      r_mode_s <= r_mode_m;
      r_mode_d <= r_mode_s;
    end
  end
  // A mode flip drops every channel back to BLOCK so the new source must settle idle first.
  assign w_mode_chg = r_mode_s ^ r_mode_d;
  assign w_src      = r_mode_s ? r_sen_s : (r_btn_s ^ BTN_ACTIVE_LOW);
  assign w_qual     = r_mode_s ? CW'(SENSOR_QUAL) : CW'(DEBOUNCE_CYCLES);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    action_channel #(
      .CW      (CW),
      .MIN_HOLD(MIN_HOLD),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_src  (w_src[i]),
      .i_force(w_mode_chg),
      .i_qual (w_qual),
      .i_clr  (clr_counts),
      .o_level(action_level[i]),
      .o_rise (action_rise[i]),
      .o_count(event_count[i*CNT_W +: CNT_W])
    );
  end
endmodule
